uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//   Downstream consumer of the UART receiver. Captures each validated byte
//   (Rx_DATA qualified by a rising Rx_VALID) into a DEPTH-entry FIFO for the
//   system-side reader. Counts framing and parity error events.
//   Receiver outputs arrive from the sample_ENABLE domain, so every control
//   input is synchronised to clk.
// PARAMETERS
//   DEPTH   8   FIFO entries; must be a power of 2, >= 2
//   ADDR_W  3   log2(DEPTH); pointer width
// PORTS
//   clk        in   1         system clock; all state changes on posedge
//   reset      in   1         asynchronous, active-low reset
//   Rx_DATA    in   8         received byte; stable while Rx_VALID is high
//   Rx_VALID   in   1         level from receiver; a rising edge means one new byte
//   Rx_FERROR  in   1         framing error level from receiver
//   Rx_PERROR  in   1         parity error level from receiver
//   rd_en      in   1         pop request; honoured only when empty=0
//   clr_flags  in   1         clears overflow, ferr_cnt and perr_cnt
//   rd_data    out  8         head entry (first-word fall-through); 0 when empty
//   empty      out  1         1 = no entries
//   full       out  1         1 = DEPTH entries
//   count      out  ADDR_W+1  occupancy, 0..DEPTH
//   overflow   out  1         sticky; a byte was dropped because the FIFO was full
//   ferr_cnt   out  8         framing error events, saturating at 255
//   perr_cnt   out  8         parity error events, saturating at 255
// BEHAVIOUR
//   Reset (reset=0, async): pointers=0, count=0, empty=1, full=0, rd_data=0,
//     overflow=0, ferr_cnt=0, perr_cnt=0, all sync/edge flops=0, armed=0.
//     A reset mid-operation discards all FIFO contents.
//   Sync: Rx_VALID, Rx_FERROR and Rx_PERROR each pass through 2 flops
//     (s1 -> s2) plus a delayed copy d. rise_x = s2 & ~d.
//   Arming: after reset release, armed goes 1 on the first clk where the
//     synced Rx_VALID (s2) is 0. Until then rise_valid is ignored, so a
//     Rx_VALID already high at release never writes a stale byte.
//   Write: wr = rise_valid & armed. Rx_DATA is sampled directly (no sync);
//     it is stable while Rx_VALID is high. Latency: Rx_VALID rises before
//     edge k -> entry written at edge k+2 -> empty=0 / count updated after k+2.
//   Read: pop = rd_en & ~empty. rd_data shows mem[rd_ptr] combinationally,
//     forced to 0 when empty. Advances on the edge where pop is true.
//   Pointers wrap modulo DEPTH. count = count + wr_ok - pop.
//   full=(count==DEPTH); empty=(count==0).
//   Full + wr + pop same cycle: both happen, count unchanged, no overflow.
//   Full + wr, no pop: byte dropped, pointers unchanged, overflow <= 1.
//   Empty + rd_en (with or without wr): the read is ignored; a wr still stores.
//   Errors: rise_ferr increments ferr_cnt; rise_perr increments perr_cnt.
//     Both may rise in the same cycle. Counters hold at 255. Error bytes are
//     never written (receiver keeps Rx_VALID=0 on error).
//   clr_flags=1: overflow, ferr_cnt and perr_cnt <= 0 on that edge. Clear wins
//     over a same-cycle set or increment. FIFO data is unaffected.
// TESTING
//   1 reset, then pulse Rx_VALID high with Rx_DATA=8'hA5 -> empty=0 after 3rd
//     clk edge, rd_data=A5, count=1; rd_en 1 cycle -> empty=1, rd_data=0.
//   2 9 bytes 01..09 with no reads -> full=1 after 8th byte, overflow=1 after
//     9th; pop 8 times -> 01..08 in order, 09 never appears.
//   3 full FIFO, new byte 8'h3C arrives in the same cycle as rd_en -> count
//     stays 8, overflow=0, 3C is read last.
//   4 Rx_FERROR rises 3 times, Rx_PERROR 2 times (one rise simultaneous with a
//     FERROR rise) -> ferr_cnt=3, perr_cnt=2; 300 FERROR rises -> 255;
//     clr_flags during an increment -> 0.
//   5 hold Rx_VALID=1 across reset release -> no write; drop Rx_VALID, raise it
//     with 8'h5A -> exactly one entry, 5A.
//   6 assert reset mid-burst (count=5) -> empty=1 and count=0 immediately
//     (async); the next valid byte is read back as the sole entry.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronised UART receive byte FIFO with error counters
// Bytes qualified by a rising Rx_VALID are queued first-word fall-through.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        Rx_DATA,
  input  logic              Rx_VALID,
  input  logic              Rx_FERROR,
  input  logic              Rx_PERROR,
  input  logic              rd_en,
  input  logic              clr_flags,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        ferr_cnt,
  output logic [7:0]        perr_cnt
);

  localparam int CW = ADDR_W + 1;

  // bit 0 = valid, bit 1 = framing error, bit 2 = parity error
  logic [2:0]        s1_q, s1_d;
  logic [2:0]        s2_q, s2_d;
  logic [2:0]        dly_q, dly_d;
  logic [2:0]        rise;
  logic [1:0]        warm_q, warm_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic              ovf_q, ovf_d;
  logic [7:0]        ferr_q, ferr_d;
  logic [7:0]        perr_q, perr_d;
  logic              empty_w, full_w;
  logic              wr, pop, wr_ok;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign rise    = s2_q & ~dly_q;

  always_comb begin
    s1_d     = {Rx_PERROR, Rx_FERROR, Rx_VALID};
    s2_d     = s1_q;
    dly_d    = s2_q;
    warm_d   = {warm_q[0], 1'b1};
    // s2 only reflects the real input once the sync chain has filled (warm_q[1]);
    // arming on the reset value would let a level held across release write.
    armed_d  = armed_q | (warm_q[1] & ~s2_q[0]);
    wr       = rise[0] & armed_q;
    pop      = rd_en & ~empty_w;
    wr_ok    = wr & (~full_w | pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = Rx_DATA;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(wr_ok) - CW'(pop);

    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    perr_d = perr_q;
    if (clr_flags) begin
      ovf_d  = 1'b0;
      ferr_d = '0;
      perr_d = '0;
    end else begin
      if (wr && !wr_ok)                ovf_d  = 1'b1;
      if (rise[1] && ferr_q != 8'hFF)  ferr_d = ferr_q + 8'd1;
      if (rise[2] && perr_q != 8'hFF)  perr_d = perr_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      dly_q    <= '0;
      warm_q   <= '0;
      armed_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= '0;
      perr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      dly_q    <= dly_d;
      warm_q   <= warm_d;
      armed_q  <= armed_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      mem_q    <= mem_d;
    end
  end

  assign rd_data  = empty_w ? 8'h00 : mem_q[rd_ptr_q];
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign ferr_cnt = ferr_q;
  assign perr_cnt = perr_q;

endmodule
